control_fsm: RTL
================

# control_fsm

Multicycle control unit for the 16-bit-instruction datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the ALU operand-select and operation controls (ALUSelA, ALUSelB, ALUOp) and the datapath register and memory enables. It consumes the ALU Zero flag and a memory-ready handshake. It sits beside the ALU and register file, between instruction register, memory interface and PC.

## Interface
- pCountWidth, 16, width of retired-instruction counter
- Clk  input  1  clock; all state changes on rising edge
- Rst_n  input  1  reset, asynchronous, active-low
- Opcode  input  4  instruction register bits [15:12]; valid from DECODE onward
- Zero  input  1  ALU zero flag
- MemReady  input  1  memory completes current read/write this cycle
- ALUSelA  output  1  0 = PC, 1 = ReadData1
- ALUSelB  output  2  00 = ReadData2, 01 = constant 1, 1x = sign-extended immediate
- ALUOp  output  2  00 = add, 01 = subtract, 10 = R-type function decode
- MemRead, MemWrite  output  1 each  memory strobes, held until MemReady
- IorD  output  1  memory address: 0 = PC, 1 = ALU result register
- IRWrite  output  1  load instruction register
- PCEn  output  1  PC load = unconditional PC write OR (branch AND Zero)
- PCSource  output  2  00 = ALU result, 01 = ALU result register (branch target), 10 = jump target
- RegWrite, RegDst, MemtoReg  output  1 each  register-file write controls
- IllegalOp  output  1  one-cycle pulse on an undefined opcode
- InstrCount  output  pCountWidth  retired-instruction count

## Operation
- Opcodes:
  - 0000 R-type
  - 0001 ADDI
  - 0010 LW
  - 0011 SW
  - 0100 BEQ
  - 0101 J
  - 0110–1111 illegal
- States. Outputs not listed are 0.
  - IDLE: reset state, all outputs 0. Next: FETCH.
  - FETCH: MemRead=1, IorD=0, ALUSelA=0, ALUSelB=01, ALUOp=00.
    - MemReady=0: stay in FETCH.
    - MemReady=1: also IRWrite=1, PCEn=1, PCSource=00. Next: DECODE.
  - DECODE: ALUSelA=0, ALUSelB=10, ALUOp=00 (computes branch target). Next by Opcode:
    - R-type → EXEC_R
    - ADDI/LW/SW → EXEC_I
    - BEQ → BRANCH
    - J → JUMP
    - illegal → FETCH, with IllegalOp=1 this cycle
  - EXEC_R: ALUSelA=1, ALUSelB=00, ALUOp=10. Next: R_WB.
  - R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
  - EXEC_I: ALUSelA=1, ALUSelB=10, ALUOp=00. Next: ADDI → I_WB, LW → MEM_RD, SW → MEM_WR.
  - I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
  - MEM_RD: MemRead=1, IorD=1. Stay until MemReady=1, then LD_WB.
  - LD_WB: RegWrite=1, RegDst=0, MemtoReg=1. Next: FETCH.
  - MEM_WR: MemWrite=1, IorD=1. Stay until MemReady=1, then FETCH.
  - BRANCH: ALUSelA=1, ALUSelB=00, ALUOp=01, PCSource=01, PCEn=Zero. Next: FETCH.
  - JUMP: PCEn=1, PCSource=10. Next: FETCH.
- InstrCount:
  - Increments by 1 on each transition into FETCH from R_WB, I_WB, LD_WB, MEM_WR, BRANCH or JUMP.
  - Wraps from all-ones to 0.
  - Not incremented for illegal opcodes or for IDLE → FETCH.
- Output decoding:
  - All outputs are combinational decodes of the state register.
  - Exceptions: PCEn and IRWrite also depend on MemReady/Zero; IllegalOp also depends on Opcode.
- Opcode is ignored outside DECODE and EXEC_I.

## Timing
- Reset:
  - Rst_n low immediately forces state IDLE and InstrCount 0, regardless of Clk.
  - All outputs read 0 while in IDLE.
  - Reset asserted mid-instruction abandons it: no further strobes, count unchanged.
- First FETCH occurs in the first cycle after the first rising edge following reset release.
- Cycles per instruction with zero memory wait: R-type 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3, illegal 2.
- Each cycle of MemReady=0 in FETCH, MEM_RD or MEM_WR adds one cycle. Strobes and address select stay stable throughout the wait.
- MemReady is ignored in all other states.
- No cycle ever asserts MemRead and MemWrite together.
- No cycle ever asserts IRWrite outside FETCH.

## Test plan
- Reset release, MemReady tied 1, Opcode=0000: state sequence IDLE, FETCH, DECODE, EXEC_R, R_WB, FETCH; EXEC_R shows ALUSelA=1, ALUSelB=00, ALUOp=10; InstrCount=1 after R_WB.
- LW with MemReady low for 3 cycles in FETCH and 2 in MEM_RD: MemRead held and IorD constant throughout; IRWrite only on the ready cycle; LD_WB asserts RegWrite=1, MemtoReg=1; total 10 cycles.
- BEQ with Zero=1, then BEQ with Zero=0: PCEn=1 with PCSource=01 in the first BRANCH state; PCEn=0 in the second; both return to FETCH; InstrCount +2.
- Opcode=1010: IllegalOp pulses exactly one cycle in DECODE; next state FETCH; InstrCount unchanged.
- Rst_n pulsed low mid MEM_WR while MemReady=0: MemWrite drops asynchronously; InstrCount=0; restart goes through IDLE.
- pCountWidth=4, sixteen J instructions: InstrCount wraps 15 → 0; each JUMP shows PCEn=1, PCSource=10.

Source files
------------

// File: rtl/control_fsm.sv
// Multicycle control unit: sequences fetch/decode/execute/memory/write-back and
// drives ALU select, datapath enables and a retired-instruction counter.
module control_fsm #(
  parameter int unsigned pCountWidth = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [3:0]             Opcode,
  input  logic                   Zero,
  input  logic                   MemReady,
  output logic                   ALUSelA,
  output logic [1:0]             ALUSelB,
  output logic [1:0]             ALUOp,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IorD,
  output logic                   IRWrite,
  output logic                   PCEn,
  output logic [1:0]             PCSource,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   MemtoReg,
  output logic                   IllegalOp,
  output logic [pCountWidth-1:0] InstrCount
);

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;

  localparam logic [1:0] SELB_REG  = 2'b00;
  localparam logic [1:0] SELB_ONE  = 2'b01;
  localparam logic [1:0] SELB_IMM  = 2'b10;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_R_WB,
    S_EXEC_I,
    S_I_WB,
    S_MEM_RD,
    S_LD_WB,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   retire_c;

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d   = state_q;
    ALUSelA   = 1'b0;
    ALUSelB   = SELB_REG;
    ALUOp     = ALU_ADD;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IorD      = 1'b0;
    IRWrite   = 1'b0;
    PCEn      = 1'b0;
    PCSource  = PC_ALU;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    IllegalOp = 1'b0;
    retire_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        MemRead = 1'b1;
        ALUSelB = SELB_ONE;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCEn    = 1'b1;
          state_d = S_DECODE;
        end
      end

      // ALU speculatively forms the branch target while the opcode is decoded
      S_DECODE: begin
        ALUSelB = SELB_IMM;
        case (Opcode)
          OP_RTYPE:              state_d = S_EXEC_R;
          OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC_I;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        ALUSelA = 1'b1;
        ALUOp   = ALU_FUNCT;
        state_d = S_R_WB;
      end

      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_EXEC_I: begin
        ALUSelA = 1'b1;
        ALUSelB = SELB_IMM;
        case (Opcode)
          OP_LW:   state_d = S_MEM_RD;
          OP_SW:   state_d = S_MEM_WR;
          default: state_d = S_I_WB;
        endcase
      end

      S_I_WB: begin
        RegWrite = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) begin
          state_d = S_LD_WB;
        end
      end

      S_LD_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_BRANCH: begin
        ALUSelA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PC_ALUOUT;
        PCEn     = Zero;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        PCEn     = 1'b1;
        PCSource = PC_JUMP;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Retired-instruction counter, wraps naturally at all-ones
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      InstrCount <= '0;
    end else if (retire_c) begin
      InstrCount <= InstrCount + pCountWidth'(1);
    end
  end

  a_strobes_exclusive: assert property (@(posedge Clk) disable iff (!Rst_n)
    !(MemRead && MemWrite));

  a_irwrite_in_fetch: assert property (@(posedge Clk) disable iff (!Rst_n)
    IRWrite |-> (state_q == S_FETCH));

endmodule
